// File: rtl/m2m_operand_sequencer_if.sv
// rtl/m2m_operand_sequencer_if.sv - memory and ALU bus between the operand sequencer and its peers
// Ports (master = sequencer side):
//   mem_addr/mem_re/mem_we/mem_wdata  out  single-port memory request
//   mem_rdata                         in   read data, one cycle after mem_re
//   alu_a/alu_b/alu_op                out  ALU operands and opcode
//   alu_result/alu_is_true            in   combinational ALU result and flag
interface m2m_operand_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          alu_is_true;

    modport master (
        output mem_addr, mem_re, mem_we, mem_wdata, alu_a, alu_b, alu_op,
        input  mem_rdata, alu_result, alu_is_true
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, mem_wdata, alu_a, alu_b, alu_op,
        output mem_rdata, alu_result, alu_is_true
    );
endinterface

// File: rtl/m2m_operand_sequencer.sv
// rtl/m2m_operand_sequencer.sv - memory-to-memory operand fetch / execute / write-back sequencer
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             instruction valid, sampled only in IDLE
//   op/src_a/src_b/dst decoded instruction fields
//   bus               master side of memory + ALU bus
//   busy              high from FETCH_A through FINISH
//   done              one-cycle pulse in FINISH
//   branch_taken      compare outcome, held until the next done
//   result            last ALU result, held until the next EXEC
module m2m_operand_sequencer #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             op,
    input  logic [AW-1:0]          src_a,
    input  logic [AW-1:0]          src_b,
    input  logic [AW-1:0]          dst,
    m2m_operand_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   branch_taken,
    output logic [DW-1:0]          result
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_LOAD_B,
        S_EXEC,
        S_FINISH
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    op_q;
    logic [AW-1:0] src_a_q;
    logic [AW-1:0] src_b_q;
    logic [AW-1:0] dst_q;
    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;
    logic [DW-1:0] result_q;
    logic          branch_q;
    logic          is_cmp;

    // Opcodes 7..12 are compares; everything else (13..15 run as add) writes back.
    assign is_cmp = (op_q >= 4'd7) && (op_q <= 4'd12);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        src_a_q <= src_a;
                        src_b_q <= src_b;
                        dst_q   <= dst;
                    end
                end
                S_FETCH_B: opa_q <= bus.mem_rdata;
                S_LOAD_B:  opb_q <= bus.mem_rdata;
                S_EXEC: begin
                    result_q <= bus.alu_result;
                    // Arithmetic ops report a constant-1 flag; mask it so only compares branch.
                    branch_q <= is_cmp & bus.alu_is_true;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        bus.mem_addr  = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH_A;
            end
            S_FETCH_A: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = src_a_q;
                state_next   = S_FETCH_B;
            end
            S_FETCH_B: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = src_b_q;
                state_next   = S_LOAD_B;
            end
            S_LOAD_B: state_next = S_EXEC;
            S_EXEC:   state_next = S_FINISH;
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
                // A reset landing on the write cycle must not commit the write.
                if (!is_cmp && !reset) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = dst_q;
                    bus.mem_wdata = result_q;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy         = (state != S_IDLE);
    assign branch_taken = branch_q;
    assign result       = result_q;
    assign bus.alu_a    = opa_q;
    assign bus.alu_b    = opb_q;
    assign bus.alu_op   = op_q;
endmodule

// File: tb/tb_m2m_operand_sequencer.sv
// tb/tb_m2m_operand_sequencer.sv - self-checking bench for m2m_operand_sequencer
module tb_m2m_operand_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [7:0]  src_a = '0;
    logic [7:0]  src_b = '0;
    logic [7:0]  dst = '0;
    logic        busy;
    logic        done;
    logic        branch_taken;
    logic [15:0] result;

    m2m_operand_sequencer_if #(.AW(8), .DW(16)) bus ();

    m2m_operand_sequencer #(.AW(8), .DW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .dst(dst), .bus(bus),
        .busy(busy), .done(done), .branch_taken(branch_taken), .result(result)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {flag, result}; arithmetic ops flag constant 1.
    function automatic logic [16:0] alu_model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            4'd0:  return {1'b1, a + b};
            4'd1:  return {1'b1, a - b};
            4'd2:  return {1'b1, a & b};
            4'd3:  return {1'b1, a | b};
            4'd4:  return {1'b1, a ^ b};
            4'd5:  return {1'b1, a << b[3:0]};
            4'd6:  return {1'b1, a >> b[3:0]};
            4'd7:  return {a == b, 15'd0, a == b};
            4'd8:  return {a != b, 15'd0, a != b};
            4'd9:  return {$signed(a) < $signed(b), 15'd0, $signed(a) < $signed(b)};
            4'd10: return {$signed(a) >= $signed(b), 15'd0, $signed(a) >= $signed(b)};
            4'd11: return {$signed(a) <= $signed(b), 15'd0, $signed(a) <= $signed(b)};
            4'd12: return {$signed(a) > $signed(b), 15'd0, $signed(a) > $signed(b)};
            default: return {1'b1, a + b};
        endcase
    endfunction

    always_comb {bus.alu_is_true, bus.alu_result} = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    // Memory model with a preload port so only this process writes mem.
    logic [15:0] mem [0:255];
    logic [15:0] ref_mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int viol = 0;
    always @(negedge clk) begin
        if (bus.mem_re && bus.mem_we) viol++;
        else if (!bus.mem_re && !bus.mem_we && bus.mem_addr != 8'd0) viol++;
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        br;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int passed = 0;

    int          obs_re_n, obs_we_n, obs_done_n, obs_we_cyc, obs_done_cyc;
    logic [7:0]  obs_rd0, obs_rd1, obs_waddr;
    logic [15:0] obs_wdata;
    logic        obs_br;

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic push_expect(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
        logic [16:0] r;
        exp_t x;
        logic cmp;
        r = alu_model(o, ref_mem[a], ref_mem[b]);
        cmp = (o >= 4'd7) && (o <= 4'd12);
        x.wr = !cmp; x.addr = d; x.data = r[15:0]; x.br = cmp ? r[16] : 1'b0;
        if (x.wr) ref_mem[d] = r[15:0];
        sb.push_back(x);
    endtask

    task automatic clear_obs();
        obs_re_n = 0; obs_we_n = 0; obs_done_n = 0; obs_we_cyc = -1; obs_done_cyc = -1;
        obs_rd0 = '0; obs_rd1 = '0; obs_waddr = '0; obs_wdata = '0; obs_br = 1'b0;
    endtask

    task automatic observe(input int c);
        if (bus.mem_re) begin
            if (obs_re_n == 0) obs_rd0 = bus.mem_addr; else obs_rd1 = bus.mem_addr;
            obs_re_n++;
        end
        if (bus.mem_we) begin
            obs_we_n++; obs_we_cyc = c; obs_waddr = bus.mem_addr; obs_wdata = bus.mem_wdata;
        end
        if (done) begin
            obs_done_n++; obs_done_cyc = c; obs_br = branch_taken;
        end
    endtask

    // Drives one instruction (start in cycle 0) and records cycles 0..6.
    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
        push_expect(o, a, b, d);
        clear_obs();
        op = o; src_a = a; src_b = b; dst = d;
        for (int c = 0; c < 7; c++) begin
            start = (c == 0);
            @(negedge clk);
            observe(c);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done, branch_taken} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, branch_taken}); else passed++;
        checks++; if ({bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 26'd0) $display("FAIL reset_mem got %h want 0", {bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata}); else passed++;
        checks++; if ({result, bus.alu_a, bus.alu_b, bus.alu_op} !== 52'd0) $display("FAIL reset_regs got %h want 0", {result, bus.alu_a, bus.alu_b, bus.alu_op}); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        preload(8'd1, 16'd100);
        preload(8'd2, -16'sd30);
        issue(4'd0, 8'd1, 8'd2, 8'd3);
        e = sb.pop_front();
        checks++; if ({obs_re_n, obs_rd0, obs_rd1} !== {32'd2, 8'd1, 8'd2}) $display("FAIL add_reads got n=%0d %0d/%0d want 2 1/2", obs_re_n, obs_rd0, obs_rd1); else passed++;
        checks++; if ({obs_we_n, obs_we_cyc} !== {32'd1, 32'd5}) $display("FAIL add_we got n=%0d cyc=%0d want 1 5", obs_we_n, obs_we_cyc); else passed++;
        checks++; if ({obs_waddr, obs_wdata} !== {e.addr, e.data} || obs_wdata !== 16'd70) $display("FAIL add_write got %0d<=%0d want %0d<=%0d", obs_waddr, obs_wdata, e.addr, e.data); else passed++;
        checks++; if ({obs_done_n, obs_done_cyc} !== {32'd1, 32'd5}) $display("FAIL add_done got n=%0d cyc=%0d want 1 5", obs_done_n, obs_done_cyc); else passed++;
        checks++; if (obs_br !== e.br) $display("FAIL add_branch got %b want %b", obs_br, e.br); else passed++;
        checks++; if (mem[3] !== 16'd70) $display("FAIL add_mem got %0d want 70", mem[3]); else passed++;
    endtask

    task automatic test_compare();
        preload(8'd4, -16'sd5);
        preload(8'd5, 16'd3);
        issue(4'd9, 8'd4, 8'd5, 8'd6);
        e = sb.pop_front();
        checks++; if ({obs_we_n, obs_done_n, obs_done_cyc} !== {32'd0, 32'd1, 32'd5}) $display("FAIL lt_we_done got we=%0d done=%0d@%0d want 0 1@5", obs_we_n, obs_done_n, obs_done_cyc); else passed++;
        checks++; if (obs_br !== e.br || obs_br !== 1'b1) $display("FAIL lt_branch got %b want %b", obs_br, e.br); else passed++;
        issue(4'd12, 8'd4, 8'd5, 8'd6);
        e = sb.pop_front();
        checks++; if (obs_we_n !== 0) $display("FAIL gt_we got %0d want 0", obs_we_n); else passed++;
        checks++; if (obs_br !== e.br || obs_br !== 1'b0) $display("FAIL gt_branch got %b want %b", obs_br, e.br); else passed++;
    endtask

    task automatic test_alias();
        preload(8'd7, 16'h1234);
        issue(4'd1, 8'd7, 8'd7, 8'd7);
        e = sb.pop_front();
        checks++; if ({obs_we_n, obs_waddr, obs_wdata} !== {32'd1, e.addr, e.data} || e.data !== 16'h0000) $display("FAIL alias_sub got n=%0d %0d<=%h want 1 %0d<=%h", obs_we_n, obs_waddr, obs_wdata, e.addr, e.data); else passed++;
        issue(4'd0, 8'd7, 8'd7, 8'd7);
        e = sb.pop_front();
        checks++; if ({obs_we_n, obs_waddr, obs_wdata} !== {32'd1, e.addr, e.data} || e.data !== 16'h0000) $display("FAIL alias_add got n=%0d %0d<=%h want 1 %0d<=%h", obs_we_n, obs_waddr, obs_wdata, e.addr, e.data); else passed++;
    endtask

    task automatic test_add_fallback();
        preload(8'd8, 16'd7);
        preload(8'd9, 16'd8);
        issue(4'd15, 8'd8, 8'd9, 8'd10);
        e = sb.pop_front();
        checks++; if ({obs_waddr, obs_wdata} !== {e.addr, e.data} || obs_wdata !== 16'd15) $display("FAIL op15_write got %0d<=%0d want %0d<=%0d", obs_waddr, obs_wdata, e.addr, e.data); else passed++;
        checks++; if (obs_br !== 1'b0) $display("FAIL op15_branch got %b want 0", obs_br); else passed++;
    endtask

    task automatic test_back_to_back();
        int done_cycles[$];
        logic [15:0] wdata[$];
        op = 4'd0; src_a = 8'd1; src_b = 8'd2; dst = 8'd11;
        push_expect(4'd0, 8'd1, 8'd2, 8'd11);
        push_expect(4'd0, 8'd1, 8'd2, 8'd11);
        for (int c = 0; c < 14; c++) begin
            start = (c <= 6);
            @(negedge clk);
            if (done) done_cycles.push_back(c);
            if (bus.mem_we) wdata.push_back(bus.mem_wdata);
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++; if (done_cycles.size() !== 2) $display("FAIL b2b_count got %0d want 2", done_cycles.size()); else passed++;
        if (done_cycles.size() == 2) begin
            checks++; if (done_cycles[0] !== 5 || done_cycles[1] !== 11) $display("FAIL b2b_cycles got %0d,%0d want 5,11", done_cycles[0], done_cycles[1]); else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            checks++;
            if (i >= wdata.size()) $display("FAIL b2b_write%0d got none want %0d", i, e.data);
            else if (wdata[i] !== e.data) $display("FAIL b2b_write%0d got %0d want %0d", i, wdata[i], e.data);
            else passed++;
        end
        // Start pulsed while busy must be dropped, not queued.
        clear_obs();
        push_expect(4'd0, 8'd1, 8'd2, 8'd11);
        for (int c = 0; c < 12; c++) begin
            start = (c == 0) || (c >= 2 && c <= 5);
            @(negedge clk);
            observe(c);
            @(posedge clk); #1;
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++; if ({obs_done_n, obs_we_n} !== {32'd1, 32'd1}) $display("FAIL pulse_ignored got done=%0d we=%0d want 1 1", obs_done_n, obs_we_n); else passed++;
        checks++; if (obs_wdata !== e.data) $display("FAIL pulse_write got %0d want %0d", obs_wdata, e.data); else passed++;
    endtask

    task automatic test_reset_mid();
        int rc;
        preload(8'd12, 16'h0042);
        preload(8'd13, 16'h0001);
        preload(8'd14, 16'h5555);
        op = 4'd0; src_a = 8'd12; src_b = 8'd13; dst = 8'd14;
        for (int k = 0; k < 2; k++) begin
            rc = (k == 0) ? 3 : 5;
            for (int c = 0; c < 8; c++) begin
                start = (c == 0);
                reset = (c == rc);
                @(negedge clk);
                if (c == 5 && k == 1) begin
                    checks++; if (result !== 16'h0043) $display("FAIL rst_pre_result got %h want 0043", result); else passed++;
                end
                if (c == rc + 1) begin
                    checks++; if ({busy, done, bus.mem_we} !== 3'b000) $display("FAIL rst%0d_flags got %b want 000", rc, {busy, done, bus.mem_we}); else passed++;
                    checks++; if (result !== 16'd0) $display("FAIL rst%0d_result got %h want 0", rc, result); else passed++;
                end
                @(posedge clk); #1;
            end
            reset = 1'b0;
            start = 1'b0;
            checks++; if (mem[14] !== ref_mem[14]) $display("FAIL rst%0d_mem got %h want %h", rc, mem[14], ref_mem[14]); else passed++;
        end
    endtask

    task automatic test_protocol();
        checks++; if (viol !== 0) $display("FAIL bus_protocol got %0d violations want 0", viol); else passed++;
        checks++; if (sb.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", sb.size()); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'd0;
        // Mirror the zeroed reference into the model memory.
        for (int i = 0; i < 16; i++) begin
            pl_addr = i[7:0]; pl_data = 16'd0; pl_en = 1'b1;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        test_reset();
        test_add();
        test_compare();
        test_alias();
        test_add_fallback();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
